// File: rtl/dsp_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_seq_pkg
//  Purpose  : Shared widths, DSP38 control constants and operand-pin modes
//             for the DSP MAC operand sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package dsp_seq_pkg;

    localparam int DSP_A_W   = 20;
    localparam int DSP_B_W   = 18;
    localparam int DSP_Z_W   = 38;
    localparam int ACC_FIR_W = 6;
    localparam int SHIFT_W   = 6;

    // FEEDBACK selection that makes the DSP accumulate onto its own Z
    localparam logic [2:0] FB_MULT_ADD = 3'b000;

    // What the sequencer drives onto the DSP operand pins in a given cycle
    typedef enum logic [1:0] {
        PIN_IDLE   = 2'd0,  // no product open: zero operands, accumulator restarts
        PIN_ISSUE  = 2'd1,  // a term was accepted this cycle
        PIN_BUBBLE = 2'd2   // product open but no term: zero operands, accumulator holds
    } pin_mode_e;

endpackage
`default_nettype wire

// File: rtl/dsp_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_result_fifo
//  Purpose  : Small synchronous FIFO holding finished dot products. Reports
//             its free-slot count so the sequencer can reserve space before
//             opening a new product.
//  Revision : 1.0 - initial release
// ============================================================================
module dsp_result_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_free
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_pop;
    logic w_full;

    assign w_do_pop = i_pop & (r_count != '0);
    assign w_full   = (r_count == c_DEPTH_CNT);

    assign o_valid  = (r_count != '0);
    assign o_data   = r_mem[r_rd_ptr];
    assign o_free   = c_DEPTH_CNT - r_count;

    // Storage array: written on push, no reset needed since o_valid gates it
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The upstream credit scheme reserves a slot before a product starts
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && w_full));

endmodule
`default_nettype wire

// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_mac_sequencer
//  Purpose  : Operand sequencer for a DSP38 in multiply-add/sub mode with
//             input and output registers. Groups NUM_TAPS terms into a dot
//             product, captures Z when the product leaves the DSP pipeline
//             and returns results through a credit-protected FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int NUM_TAPS    = 8,
    parameter int DSP_LATENCY = 2,
    parameter int RES_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 lreset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DSP_A_W-1:0]   s_a,
    input  logic [DSP_B_W-1:0]   s_b,
    input  logic                 s_sub,
    input  logic                 cfg_unsigned_a,
    input  logic                 cfg_unsigned_b,
    input  logic [SHIFT_W-1:0]   cfg_shift,
    input  logic                 cfg_round,
    input  logic                 cfg_sat,
    output logic [DSP_A_W-1:0]   dsp_a,
    output logic [DSP_B_W-1:0]   dsp_b,
    output logic                 dsp_load_acc,
    output logic                 dsp_subtract,
    output logic [2:0]           dsp_feedback,
    output logic [ACC_FIR_W-1:0] dsp_acc_fir,
    output logic [SHIFT_W-1:0]   dsp_shift_right,
    output logic                 dsp_round,
    output logic                 dsp_saturate,
    output logic                 dsp_unsigned_a,
    output logic                 dsp_unsigned_b,
    input  logic [DSP_Z_W-1:0]   dsp_z,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DSP_Z_W-1:0]   m_data
);

    localparam int TAP_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int FREE_W = $clog2(RES_DEPTH) + 1;
    localparam int CMP_W  = 16;
    localparam logic [TAP_W-1:0] c_LAST_TAP = TAP_W'(NUM_TAPS - 1);

    logic [TAP_W-1:0]       r_tap;
    logic [DSP_A_W-1:0]     r_dsp_a;
    logic [DSP_B_W-1:0]     r_dsp_b;
    logic                   r_load_acc;
    logic                   r_subtract;
    logic [SHIFT_W-1:0]     r_shift;
    logic                   r_round;
    logic                   r_sat;
    logic                   r_unsigned_a;
    logic                   r_unsigned_b;
    // r_last_q marks a last tap sitting on the DSP pins; r_pipe follows it
    // through the DSP input and output registers.
    logic                   r_last_q;
    logic [DSP_LATENCY-1:0] r_pipe;

    logic                   w_accept;
    logic                   w_is_last;
    logic                   w_push;
    logic                   w_pop;
    logic [FREE_W-1:0]      w_free;
    logic [CMP_W-1:0]       w_inflight;
    pin_mode_e              w_mode;

    assign w_accept  = s_valid & s_ready;
    assign w_is_last = (r_tap == c_LAST_TAP);
    assign w_push    = r_pipe[DSP_LATENCY-1];
    assign w_pop     = m_valid & m_ready;

    // Tap 0 may only start when a result slot is guaranteed; later taps never stall
    assign s_ready = ~lreset & ((r_tap != '0) | (CMP_W'(w_free) > w_inflight));

    assign dsp_a           = r_dsp_a;
    assign dsp_b           = r_dsp_b;
    assign dsp_load_acc    = r_load_acc;
    assign dsp_subtract    = r_subtract;
    assign dsp_feedback    = FB_MULT_ADD;
    assign dsp_acc_fir     = '0;
    assign dsp_shift_right = r_shift;
    assign dsp_round       = r_round;
    assign dsp_saturate    = r_sat;
    assign dsp_unsigned_a  = r_unsigned_a;
    assign dsp_unsigned_b  = r_unsigned_b;

    // Count products that are committed but not yet written into the FIFO
    always_comb begin
        w_inflight = CMP_W'(r_last_q);
        for (int i = 0; i < DSP_LATENCY; i++) begin
            w_inflight = w_inflight + CMP_W'(r_pipe[i]);
        end
    end

    // Decide what the operand pins carry next cycle
    always_comb begin
        if (w_accept) begin
            w_mode = PIN_ISSUE;
        end else if (r_tap != '0) begin
            w_mode = PIN_BUBBLE;
        end else begin
            w_mode = PIN_IDLE;
        end
    end

    // Tap counter: advances per accepted term, wraps after the last tap
    always_ff @(posedge clk) begin
        if (lreset) begin
            r_tap <= '0;
        end else if (w_accept) begin
            r_tap <= w_is_last ? '0 : r_tap + TAP_W'(1);
        end
    end

    // Registered DSP operand and control pins
    always_ff @(posedge clk) begin
        if (lreset) begin
            r_dsp_a    <= '0;
            r_dsp_b    <= '0;
            r_load_acc <= 1'b0;
            r_subtract <= 1'b0;
        end else begin
            case (w_mode)
                PIN_ISSUE: begin
                    r_dsp_a    <= s_a;
                    r_dsp_b    <= s_b;
                    r_load_acc <= (r_tap != '0);
                    r_subtract <= s_sub;
                end
                PIN_BUBBLE: begin
                    r_dsp_a    <= '0;
                    r_dsp_b    <= '0;
                    r_load_acc <= 1'b1;
                    r_subtract <= 1'b0;
                end
                default: begin
                    r_dsp_a    <= '0;
                    r_dsp_b    <= '0;
                    r_load_acc <= 1'b0;
                    r_subtract <= 1'b0;
                end
            endcase
        end
    end

    // Registered copies of the static output-stage configuration
    always_ff @(posedge clk) begin
        if (lreset) begin
            r_shift      <= '0;
            r_round      <= 1'b0;
            r_sat        <= 1'b0;
            r_unsigned_a <= 1'b0;
            r_unsigned_b <= 1'b0;
        end else begin
            r_shift      <= cfg_shift;
            r_round      <= cfg_round;
            r_sat        <= cfg_sat;
            r_unsigned_a <= cfg_unsigned_a;
            r_unsigned_b <= cfg_unsigned_b;
        end
    end

    // Last-tap flag tracks the product through the DSP so Z is captured once valid
    always_ff @(posedge clk) begin
        if (lreset) begin
            r_last_q <= 1'b0;
            r_pipe   <= '0;
        end else begin
            r_last_q  <= w_accept & w_is_last;
            r_pipe[0] <= r_last_q;
            for (int i = 1; i < DSP_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    dsp_result_fifo #(
        .WIDTH (DSP_Z_W),
        .DEPTH (RES_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst     (lreset),
        .i_push  (w_push),
        .i_data  (dsp_z),
        .i_pop   (w_pop),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_free  (w_free)
    );

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_mac_sequencer
//  Purpose  : Self-checking bench for dsp_mac_sequencer with a behavioural
//             DSP38 (latency 2, signed) and an arithmetic dot-product model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_sequencer;
    import dsp_seq_pkg::*;

    localparam int NUM_TAPS    = 4;
    localparam int DSP_LATENCY = 2;
    localparam int RES_DEPTH   = 4;

    logic                 clk = 1'b0;
    logic                 lreset;
    logic                 s_valid;
    logic                 s_ready;
    logic [DSP_A_W-1:0]   s_a;
    logic [DSP_B_W-1:0]   s_b;
    logic                 s_sub;
    logic                 cfg_unsigned_a, cfg_unsigned_b;
    logic [SHIFT_W-1:0]   cfg_shift;
    logic                 cfg_round, cfg_sat;
    logic [DSP_A_W-1:0]   dsp_a;
    logic [DSP_B_W-1:0]   dsp_b;
    logic                 dsp_load_acc, dsp_subtract;
    logic [2:0]           dsp_feedback;
    logic [ACC_FIR_W-1:0] dsp_acc_fir;
    logic [SHIFT_W-1:0]   dsp_shift_right;
    logic                 dsp_round, dsp_saturate, dsp_unsigned_a, dsp_unsigned_b;
    logic [DSP_Z_W-1:0]   dsp_z;
    logic                 m_valid;
    logic                 m_ready;
    logic [DSP_Z_W-1:0]   m_data;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(
        .NUM_TAPS    (NUM_TAPS),
        .DSP_LATENCY (DSP_LATENCY),
        .RES_DEPTH   (RES_DEPTH)
    ) dut (
        .clk             (clk),
        .lreset          (lreset),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_a             (s_a),
        .s_b             (s_b),
        .s_sub           (s_sub),
        .cfg_unsigned_a  (cfg_unsigned_a),
        .cfg_unsigned_b  (cfg_unsigned_b),
        .cfg_shift       (cfg_shift),
        .cfg_round       (cfg_round),
        .cfg_sat         (cfg_sat),
        .dsp_a           (dsp_a),
        .dsp_b           (dsp_b),
        .dsp_load_acc    (dsp_load_acc),
        .dsp_subtract    (dsp_subtract),
        .dsp_feedback    (dsp_feedback),
        .dsp_acc_fir     (dsp_acc_fir),
        .dsp_shift_right (dsp_shift_right),
        .dsp_round       (dsp_round),
        .dsp_saturate    (dsp_saturate),
        .dsp_unsigned_a  (dsp_unsigned_a),
        .dsp_unsigned_b  (dsp_unsigned_b),
        .dsp_z           (dsp_z),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data)
    );

    // Behavioural DSP38: input register stage, then multiply-add into Z
    logic [DSP_A_W-1:0]        r_ia;
    logic [DSP_B_W-1:0]        r_ib;
    logic                      r_ild, r_isub;
    logic signed [DSP_Z_W-1:0] w_sa, w_sb, w_p;
    assign w_sa = {{(DSP_Z_W-DSP_A_W){r_ia[DSP_A_W-1]}}, r_ia};
    assign w_sb = {{(DSP_Z_W-DSP_B_W){r_ib[DSP_B_W-1]}}, r_ib};
    assign w_p  = w_sa * w_sb;

    always @(posedge clk) begin
        if (lreset) begin
            r_ia <= '0; r_ib <= '0; r_ild <= 1'b0; r_isub <= 1'b0; dsp_z <= '0;
        end else begin
            r_ia   <= dsp_a;
            r_ib   <= dsp_b;
            r_ild  <= dsp_load_acc;
            r_isub <= dsp_subtract;
            dsp_z  <= (r_ild ? dsp_z : '0) + (r_isub ? -w_p : w_p);
        end
    end

    // Record every result that leaves the stream
    logic [DSP_Z_W-1:0] got_q[$];
    logic [DSP_Z_W-1:0] exp_q[$];
    always @(negedge clk) begin
        if (m_valid && m_ready) got_q.push_back(m_data);
    end

    int     n_assert = 0;
    int     n_fail   = 0;
    longint ref_acc  = 0;
    int     ref_tap  = 0;
    int     n_acc    = 0;
    bit     done5, tog_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one term, wait (bounded) for its handshake, feed the reference model
    task automatic send_term(input logic [DSP_A_W-1:0] a, input logic [DSP_B_W-1:0] b, input logic sub);
        bit     ok = 1'b0;
        longint prod;
        s_valid = 1'b1; s_a = a; s_b = b; s_sub = sub;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        chk("term_accept", ok, 1);
        if (ok) begin
            n_acc++;
            prod    = longint'($signed(a)) * longint'($signed(b));
            ref_acc = sub ? ref_acc - prod : ref_acc + prod;
            ref_tap++;
            if (ref_tap == NUM_TAPS) begin
                exp_q.push_back(DSP_Z_W'(ref_acc));
                ref_acc = 0;
                ref_tap = 0;
            end
        end
    endtask

    task automatic send_product(input logic [NUM_TAPS-1:0][DSP_A_W-1:0] a,
                                input logic [NUM_TAPS-1:0][DSP_B_W-1:0] b,
                                input logic [NUM_TAPS-1:0] sub);
        for (int i = 0; i < NUM_TAPS; i++) send_term(a[i], b[i], sub[i]);
        s_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 300 && got_q.size() < n; i++) @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Wait for all expected results, check count (no extras) and order/values
    task automatic drain_check(input string tag);
        wait_got(exp_q.size());
        repeat (8) @(posedge clk);
        #1;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) chk(tag, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    logic [NUM_TAPS-1:0][DSP_A_W-1:0] a_std, a_neg;
    logic [NUM_TAPS-1:0][DSP_B_W-1:0] b_std, b_sev;
    logic [NUM_TAPS-1:0][DSP_A_W-1:0] a_r [6];
    logic [NUM_TAPS-1:0][DSP_B_W-1:0] b_r [6];
    logic [NUM_TAPS-1:0]              sub_r [6];

    initial begin
        a_std = {20'd4, 20'd3, 20'd2, 20'd1};
        b_std = {18'd8, 18'd7, 18'd6, 18'd5};
        a_neg = {4{20'hFFFFD}};
        b_sev = {4{18'd7}};

        // Reset: hold with live inputs and non-zero cfg, every output must be 0
        lreset = 1'b1; m_ready = 1'b1;
        s_valid = 1'b1; s_a = 20'h12345; s_b = 18'h1ABCD; s_sub = 1'b1;
        cfg_shift = 6'h2A; cfg_round = 1'b1; cfg_sat = 1'b1;
        cfg_unsigned_a = 1'b1; cfg_unsigned_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_dsp_a", dsp_a, 0);
        chk("rst_dsp_b", dsp_b, 0);
        chk("rst_load_acc", dsp_load_acc, 0);
        chk("rst_subtract", dsp_subtract, 0);
        chk("rst_shift", dsp_shift_right, 0);
        chk("rst_round_sat", {dsp_round, dsp_saturate}, 0);
        chk("rst_unsigned", {dsp_unsigned_a, dsp_unsigned_b}, 0);
        chk("feedback", dsp_feedback, 0);
        chk("acc_fir", dsp_acc_fir, 0);
        @(posedge clk); #1;
        s_valid = 1'b0; lreset = 1'b0;
        @(posedge clk); #1;
        chk("cfg_shift_copy", dsp_shift_right, 6'h2A);
        chk("cfg_flags_copy", {dsp_round, dsp_saturate, dsp_unsigned_a, dsp_unsigned_b}, 4'hF);
        chk("ready_after_rst", s_ready, 1);
        cfg_shift = '0; cfg_round = 1'b0; cfg_sat = 1'b0;
        cfg_unsigned_a = 1'b0; cfg_unsigned_b = 1'b0;
        @(posedge clk); #1;

        // 1: back-to-back product, result appears DSP_LATENCY+1 cycles after last handshake
        send_product(a_std, b_std, 4'b0000);
        @(negedge clk); chk("t1_lat0", m_valid, 0);
        @(negedge clk); chk("t1_lat1", m_valid, 0);
        @(negedge clk); chk("t1_lat2", m_valid, 0);
        @(negedge clk); chk("t1_lat3", m_valid, 1);
        chk("t1_data", m_data, 38'd70);
        @(posedge clk); #1;
        drain_check("t1");
        @(negedge clk);
        chk("idle_load_acc", dsp_load_acc, 0);
        chk("idle_a", dsp_a, 0);
        @(posedge clk); #1;

        // 2: subtract on tap 2
        send_product(a_std, b_std, 4'b0100);
        wait_got(1);
        chk("t2_data", got_q[0], 38'd28);
        drain_check("t2");

        // 3: bubble between taps 1 and 2, accumulator must hold
        send_term(20'd1, 18'd5, 1'b0);
        send_term(20'd2, 18'd6, 1'b0);
        s_valid = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t3_bubble_load_acc", dsp_load_acc, 1);
            chk("t3_bubble_ab", {dsp_a, dsp_b}, 0);
            chk("t3_bubble_sub", dsp_subtract, 0);
        end
        @(posedge clk); #1;
        send_term(20'd3, 18'd7, 1'b0);
        send_term(20'd4, 18'd8, 1'b0);
        s_valid = 1'b0;
        wait_got(1);
        chk("t3_data", got_q[0], 38'd70);
        drain_check("t3");

        // 4: negative operand
        send_product(a_neg, b_sev, 4'b0000);
        wait_got(1);
        chk("t4_data", got_q[0], 38'h3F_FFFF_FFAC);
        drain_check("t4");

        // 5: back-pressure, random operands; only RES_DEPTH products may start
        for (int p = 0; p < 6; p++) begin
            for (int t = 0; t < NUM_TAPS; t++) begin
                a_r[p][t] = DSP_A_W'($urandom());
                b_r[p][t] = DSP_B_W'($urandom());
            end
            sub_r[p] = NUM_TAPS'($urandom());
        end
        m_ready = 1'b0; done5 = 1'b0; n_acc = 0;
        fork
            begin
                for (int p = 0; p < 6; p++) send_product(a_r[p], b_r[p], sub_r[p]);
                done5 = 1'b1;
            end
        join_none
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("t5_terms_taken", n_acc, 4 * NUM_TAPS);
        chk("t5_s_ready_blocked", s_ready, 0);
        chk("t5_m_valid", m_valid, 1);
        chk("t5_head", m_data, exp_q[0]);
        chk("t5_none_popped", got_q.size(), 0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int i = 0; i < 300 && !done5; i++) @(posedge clk);
        #1;
        chk("t5_stream_done", done5, 1);
        drain_check("t5");

        // 7: random products with random bubbles and random result back-pressure
        tog_done = 1'b0;
        fork
            begin
                repeat (200) begin @(posedge clk); #1; m_ready = 1'($urandom_range(0, 1)); end
                m_ready = 1'b1;
                tog_done = 1'b1;
            end
        join_none
        for (int p = 0; p < 8; p++) begin
            for (int t = 0; t < NUM_TAPS; t++) begin
                send_term(DSP_A_W'($urandom()), DSP_B_W'($urandom()), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) begin
                    s_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
        end
        s_valid = 1'b0;
        for (int i = 0; i < 400 && !tog_done; i++) @(posedge clk);
        #1;
        chk("t7_toggler_done", tog_done, 1);
        drain_check("t7");

        // 6: reset mid-product discards the partial sum
        send_term(20'd9, 18'd9, 1'b0);
        send_term(20'd9, 18'd9, 1'b0);
        s_valid = 1'b0;
        lreset = 1'b1;
        ref_acc = 0; ref_tap = 0;
        repeat (2) @(posedge clk);
        #1;
        lreset = 1'b0;
        send_product(a_std, b_std, 4'b0000);
        wait_got(1);
        chk("t6_data", got_q[0], 38'd70);
        drain_check("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
